// File: rtl/jt900h_div_seq.sv
// jt900h_div_seq: DIV/DIVS execution sequencer wrapped around the unsigned
// restoring divider jt900h_div.
// The sequencer takes a divide request and launches the divider on operand
// magnitudes. It waits for the divider, then fixes up the result signs and
// raises the divide-by-zero and overflow flags.
// Build option: define JT900H_DIVS_EN to compile in the signed path
// (operand magnitudes, sign fix-up, signed overflow). Without it every
// division is unsigned, `sgn` is ignored and `ov` mirrors `dz`.
module jt900h_div_seq (
    input  logic        clk,
    input  logic        rst_n,
    // request side (ALU / microcode)
    input  logic        req,
    input  logic        sgn,
    input  logic        len,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    // divider side
    output logic        div_start,
    output logic        div_len,
    output logic [15:0] div_op0,
    output logic [15:0] div_op1,
    input  logic [15:0] div_quot,
    input  logic [15:0] div_rem,
    input  logic        div_busy,
    // result side
    output logic        busy,
    output logic        done,
    output logic [15:0] quot,
    output logic [15:0] rem,
    output logic        ov,
    output logic        dz
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PREP   = 3'd1,
        LAUNCH = 3'd2,
        WAIT   = 3'd3,
        FIX    = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t state, state_nxt;

    // Latched request
    logic        len_r;
    logic        dz_r;
    logic [15:0] op_a;
    logic [15:0] op_b;

    // Raw unsigned results captured when the divider finishes
    logic [15:0] q_raw;
    logic [15:0] r_raw;

    // Result candidates presented to the output registers while in FIX
    logic [15:0] q_mag;
    logic [15:0] r_mag;
    logic [15:0] fix_quot;
    logic [15:0] fix_rem;
    logic        fix_ov;

    logic        accept;
    logic        divisor_zero;

    // Keep only the active width: byte mode clears the upper byte.
    function automatic logic [15:0] in_width(input logic [15:0] x, input logic word);
        return word ? x : {8'h00, x[7:0]};
    endfunction

`ifdef JT900H_DIVS_EN
    logic sgn_r;
    logic neg_a;
    logic neg_b;
    logic neg_q;

    function automatic logic msb(input logic [15:0] x, input logic word);
        return word ? x[15] : x[7];
    endfunction

    function automatic logic [15:0] neg_width(input logic [15:0] x, input logic word);
        return in_width(~x + 16'd1, word);
    endfunction

    // Magnitude of a two's-complement value in the active width
    function automatic logic [15:0] mag(input logic [15:0] x, input logic word, input logic s);
        return (s && msb(x, word)) ? neg_width(x, word) : in_width(x, word);
    endfunction
`else
    // Only the signed build looks at the sign request.
    logic unused_sgn;
    assign unused_sgn = sgn;
`endif

    // A request is only taken in IDLE and never while the divider is still
    // running, e.g. after a reset abandoned an operation.
    assign accept       = (state == IDLE) && req && !div_busy;
    assign divisor_zero = (in_width(divisor, len) == 16'h0000);

    // State register
    always_ff @(posedge clk) begin
        // NOTE: every clocked block uses non-blocking assignments so all state
        // updates see the values from before the edge, whatever the block order.
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode and the divider start strobe
    always_comb begin
        // NOTE: defaults first, so every path assigns every output and no
        // latch is inferred.
        state_nxt = state;
        div_start = 1'b0;
        case (state)
            IDLE:    if (accept) state_nxt = divisor_zero ? FIX : PREP;
            PREP:    state_nxt = LAUNCH;
            LAUNCH: begin
                div_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT:    if (!div_busy) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the request when it is accepted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_r <= 1'b0;
            dz_r  <= 1'b0;
            op_a  <= 16'h0000;
            op_b  <= 16'h0000;
`ifdef JT900H_DIVS_EN
            sgn_r <= 1'b0;
`endif
        end else if (accept) begin
            len_r <= len;
            dz_r  <= divisor_zero;
            op_a  <= dividend;
            op_b  <= divisor;
`ifdef JT900H_DIVS_EN
            sgn_r <= sgn;
`endif
        end
    end

    // Present operand magnitudes to the divider; held outside PREP
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_len <= 1'b0;
            div_op0 <= 16'h0000;
            div_op1 <= 16'h0000;
`ifdef JT900H_DIVS_EN
            neg_a   <= 1'b0;
            neg_b   <= 1'b0;
`endif
        end else if (state == PREP) begin
            div_len <= len_r;
`ifdef JT900H_DIVS_EN
            div_op0 <= mag(op_a, len_r, sgn_r);
            div_op1 <= mag(op_b, len_r, sgn_r);
            neg_a   <= sgn_r & msb(op_a, len_r);
            neg_b   <= sgn_r & msb(op_b, len_r);
`else
            div_op0 <= in_width(op_a, len_r);
            div_op1 <= in_width(op_b, len_r);
`endif
        end
    end

    // Snapshot the divider results on the cycle it reports completion
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_raw <= 16'h0000;
            r_raw <= 16'h0000;
        end else if (state == WAIT && !div_busy) begin
            q_raw <= div_quot;
            r_raw <= div_rem;
        end
    end

    // Sign fix-up, overflow detection and the divide-by-zero override
    always_comb begin
        q_mag    = in_width(q_raw, len_r);
        r_mag    = in_width(r_raw, len_r);
        fix_quot = q_mag;
        fix_rem  = r_mag;
        fix_ov   = 1'b0;
`ifdef JT900H_DIVS_EN
        // Sign flags are zero for unsigned requests, so no negation happens.
        neg_q = neg_a ^ neg_b;
        if (neg_q) begin
            fix_quot = neg_width(q_mag, len_r);
        end
        if (neg_a) begin
            fix_rem = neg_width(r_mag, len_r);
        end
        // A negative result may reach -2^(n-1); a positive one only 2^(n-1)-1.
        if (sgn_r) begin
            if (neg_q) fix_ov = q_mag > (len_r ? 16'h8000 : 16'h0080);
            else       fix_ov = q_mag > (len_r ? 16'h7FFF : 16'h007F);
        end
`endif
        // Zero divisor: the divider never ran, so raw results are stale.
        if (dz_r) begin
            fix_quot = len_r ? 16'hFFFF : 16'h00FF;
            fix_rem  = in_width(op_a, len_r);
            fix_ov   = 1'b1;
        end
    end

    // Handshake flags and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
            quot <= 16'h0000;
            rem  <= 16'h0000;
            ov   <= 1'b0;
            dz   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                busy <= 1'b1;
            end
            if (state == FIX) begin
                quot <= fix_quot;
                rem  <= fix_rem;
                ov   <= fix_ov;
                dz   <= dz_r;
            end
            if (state == DONE) begin
                done <= 1'b1;
                busy <= 1'b0;
            end
        end
    end

    // The start strobe is a single-cycle pulse.
    a_start_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        div_start |=> !div_start);

    // Completion is never reported while an operation is still in progress.
    a_done_idle: assert property (@(posedge clk) disable iff (!rst_n)
        done |-> !busy);

endmodule

// File: tb/tb_jt900h_div_seq.sv
// Testbench for jt900h_div_seq: directed vectors with hand-computed results.
// A behavioural stand-in for jt900h_div answers the start pulse. It stays
// busy for 15 (word) or 7 (byte) cycles after the start edge, which gives the
// 20 / 12 edge request-to-done latencies. A driver pushes expected results
// into a scoreboard queue, and a monitor pops and compares them on every
// `done`. Expected values for signed vectors depend on JT900H_DIVS_EN.
`timescale 1ns/1ps
module tb_jt900h_div_seq;

`ifdef JT900H_DIVS_EN
    localparam bit DIVS = 1'b1;
`else
    localparam bit DIVS = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        sgn;
    logic        len;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        div_start;
    logic        div_len;
    logic [15:0] div_op0;
    logic [15:0] div_op1;
    logic [15:0] div_quot;
    logic [15:0] div_rem;
    logic        div_busy;
    logic        busy;
    logic        done;
    logic [15:0] quot;
    logic [15:0] rem;
    logic        ov;
    logic        dz;

    logic        pwr_n;            // bench power-on reset (the divider ignores rst_n)
    logic        div_busy_at_edge; // div_busy as sampled by the last rising edge
    int          cyc;
    int          checks;
    int          errors;
    int          starts_seen;

    typedef struct packed {
        logic        s;
        logic        l;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        ov;
        logic        dz;
        logic [7:0]  lat;
    } vec_t;

    typedef struct {
        vec_t v;
        int   id;
        int   acc;
    } exp_t;

    vec_t  vecs[$];
    string names[$];
    exp_t  sb[$];
    exp_t  mon_e;

    jt900h_div_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .sgn       (sgn),
        .len       (len),
        .dividend  (dividend),
        .divisor   (divisor),
        .div_start (div_start),
        .div_len   (div_len),
        .div_op0   (div_op0),
        .div_op1   (div_op1),
        .div_quot  (div_quot),
        .div_rem   (div_rem),
        .div_busy  (div_busy),
        .busy      (busy),
        .done      (done),
        .quot      (quot),
        .rem       (rem),
        .ov        (ov),
        .dz        (dz)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- divider stand-in ----------------
    logic [3:0]  mdl_cnt;
    logic [15:0] mdl_q;
    logic [15:0] mdl_r;
    logic [15:0] mdl_a;
    logic [15:0] mdl_b;

    assign mdl_a = div_len ? div_op0 : {8'h00, div_op0[7:0]};
    assign mdl_b = div_len ? div_op1 : {8'h00, div_op1[7:0]};

    always @(posedge clk) begin
        if (!pwr_n) begin
            div_busy <= 1'b0;
            mdl_cnt  <= 4'd0;
            mdl_q    <= 16'h0000;
            mdl_r    <= 16'h0000;
            div_quot <= 16'h0000;
            div_rem  <= 16'h0000;
        end else if (div_start && !div_busy) begin
            div_busy <= 1'b1;
            mdl_cnt  <= div_len ? 4'd14 : 4'd6;
            mdl_q    <= (mdl_b == 16'h0000) ? 16'hFFFF : mdl_a / mdl_b;
            mdl_r    <= (mdl_b == 16'h0000) ? mdl_a : mdl_a % mdl_b;
        end else if (div_busy) begin
            if (mdl_cnt == 4'd0) begin
                div_busy <= 1'b0;
                div_quot <= mdl_q;
                div_rem  <= mdl_r;
            end else begin
                mdl_cnt <= mdl_cnt - 4'd1;
            end
        end
    end

    always @(posedge clk) begin
        if (!pwr_n) cyc <= 0;
        else        cyc <= cyc + 1;
        div_busy_at_edge <= div_busy;
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pop one expectation per done pulse
    always @(negedge clk) begin
        if (!rst_n) begin
            starts_seen = 0;
        end else begin
            if (div_start) starts_seen = starts_seen + 1;
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected done", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check({names[mon_e.id], " quot"}, quot, mon_e.v.q);
                    check({names[mon_e.id], " rem"}, rem, mon_e.v.r);
                    check({names[mon_e.id], " ov"}, ov, mon_e.v.ov);
                    check({names[mon_e.id], " dz"}, dz, mon_e.v.dz);
                    check({names[mon_e.id], " latency"}, cyc - mon_e.acc, 32'(mon_e.v.lat));
                    check({names[mon_e.id], " start pulses"}, starts_seen,
                          (mon_e.v.lat == 8'd2) ? 32'd0 : 32'd1);
                end
                starts_seen = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic add(input string name, input logic s, input logic l,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] q, input logic [15:0] r,
                       input logic e_ov, input logic e_dz, input logic [7:0] lat);
        vec_t v;
        v = '{s: s, l: l, a: a, b: b, q: q, r: r, ov: e_ov, dz: e_dz, lat: lat};
        vecs.push_back(v);
        names.push_back(name);
    endtask

    // Drive one request, wait until it is accepted, push the expectation.
    task automatic issue(input int id, input bit keep, output int waited);
        exp_t e;
        int   n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) check({names[id], " idle timeout"}, busy, 1'b0);
        sgn      = vecs[id].s;
        len      = vecs[id].l;
        dividend = vecs[id].a;
        divisor  = vecs[id].b;
        req      = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!busy && n < 100);
        waited = n;
        if (!busy) begin
            check({names[id], " accept timeout"}, busy, 1'b1);
            req = 1'b0;
            return;
        end
        check({names[id], " accepted with divider idle"}, div_busy_at_edge, 1'b0);
        e.v   = vecs[id];
        e.id  = id;
        e.acc = cyc;
        sb.push_back(e);
        if (!keep) req = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, " all results returned"}, sb.size(), 0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " busy"}, busy, 1'b0);
        check({tag, " done"}, done, 1'b0);
        check({tag, " div_start"}, div_start, 1'b0);
        check({tag, " quot"}, quot, 16'h0000);
        check({tag, " rem"}, rem, 16'h0000);
        check({tag, " ov"}, ov, 1'b0);
        check({tag, " dz"}, dz, 1'b0);
        check({tag, " div_op0"}, div_op0, 16'h0000);
        check({tag, " div_op1"}, div_op1, 16'h0000);
        check({tag, " div_len"}, div_len, 1'b0);
    endtask

    int w;
    int n_main;

    initial begin
        checks   = 0;
        errors   = 0;
        pwr_n    = 1'b0;
        rst_n    = 1'b0;
        req      = 1'b0;
        sgn      = 1'b0;
        len      = 1'b0;
        dividend = 16'h0000;
        divisor  = 16'h0000;

        //   name               sgn len  dividend  divisor   quot                        rem                         ov    dz lat
        add("uword 1000/7",     0,  1,   16'd1000, 16'd7,    16'd142,                    16'd6,                      0,    0, 20);
        add("byte -7/2",        1,  0,   16'h00F9, 16'h0002, DIVS ? 16'h00FD : 16'h007C, DIVS ? 16'h00FF : 16'h0001, 0,    0, 12);
        add("dz byte 45/00",    1,  0,   16'hAB45, 16'h1200, 16'h00FF,                   16'h0045,                   1,    1, 2);
        add("word 8000/FFFF",   1,  1,   16'h8000, 16'hFFFF, DIVS ? 16'h8000 : 16'h0000, DIVS ? 16'h0000 : 16'h8000, DIVS, 0, 20);
        add("byte 80/FF",       1,  0,   16'h0080, 16'h00FF, DIVS ? 16'h0080 : 16'h0000, DIVS ? 16'h0000 : 16'h0080, DIVS, 0, 12);
        add("dz word",          1,  1,   16'h1234, 16'h0000, 16'hFFFF,                   16'h1234,                   1,    1, 2);
        add("word -32768/1",    1,  1,   16'h8000, 16'h0001, 16'h8000,                   16'h0000,                   0,    0, 20);
        add("word 100/-7",      1,  1,   16'h0064, 16'hFFF9, DIVS ? 16'hFFF2 : 16'h0000, DIVS ? 16'h0002 : 16'h0064, 0,    0, 20);
        add("byte -100/-7",     1,  0,   16'h009C, 16'h00F9, DIVS ? 16'h000E : 16'h0000, DIVS ? 16'h00FE : 16'h009C, 0,    0, 12);
        add("byte -127/-1",     1,  0,   16'h0081, 16'h00FF, DIVS ? 16'h007F : 16'h0000, DIVS ? 16'h0000 : 16'h0081, 0,    0, 12);
        add("ubyte 200/5",      0,  0,   16'hFFC8, 16'h3305, 16'h0028,                   16'h0000,                   0,    0, 12);
        add("uword FFFF/1",     0,  1,   16'hFFFF, 16'h0001, 16'hFFFF,                   16'h0000,                   0,    0, 20);
        n_main = vecs.size();
        add("b2b first",        0,  1,   16'h1000, 16'h0010, 16'h0100,                   16'h0000,                   0,    0, 20);
        add("b2b second",       0,  0,   16'h0063, 16'h000A, 16'h0009,                   16'h0009,                   0,    0, 12);
        add("aborted word",     0,  1,   16'h4444, 16'h0003, 16'h16C1,                   16'h0001,                   0,    0, 20);
        add("after reset",      0,  1,   16'hF000, 16'h0010, 16'h0F00,                   16'h0000,                   0,    0, 20);

        repeat (3) @(negedge clk);
        pwr_n = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Independent operations
        for (int i = 0; i < n_main; i++) begin
            issue(i, 1'b0, w);
        end
        drain("directed");

        // Back-to-back: req stays high through the first done
        issue(n_main, 1'b1, w);
        issue(n_main + 1, 1'b0, w);
        check("b2b second accepted on edge after done", w, 1);
        drain("b2b");

        // Reset in the middle of a word operation
        issue(n_main + 2, 1'b0, w);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        repeat (5) @(negedge clk);
        check_reset_state("mid-op reset");
        check("divider still busy after reset", div_busy, 1'b1);
        rst_n = 1'b1;
        issue(n_main + 3, 1'b0, w);
        drain("after reset");

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
